// File: rtl/periph_sram_slave.sv
// Memory-mapped peripheral slave on a simple SRAM-style bus: LED, switches, free-running timer
// with compare interrupt, and a scratch register. Reads return data one cycle after the request.
module periph_sram_slave #(
    parameter logic [31:0] ADDR_MASK = 32'h0000_00FF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [7:0]  switch_in,
    output logic [15:0] led_out,
    output logic        timer_int
);

    localparam logic [29:0] IdxLed     = 30'd0;
    localparam logic [29:0] IdxSwitch  = 30'd1;
    localparam logic [29:0] IdxTimer   = 30'd2;
    localparam logic [29:0] IdxCompare = 30'd3;
    localparam logic [29:0] IdxStatus  = 30'd4;
    localparam logic [29:0] IdxScratch = 30'd5;

    logic [15:0] led_q, led_d;
    logic [7:0]  sw1_q, sw1_d, sw2_q, sw2_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] compare_q, compare_d;
    logic        pend_q, pend_d;
    logic        ien_q, ien_d;
    logic [31:0] scratch_q, scratch_d;
    logic [31:0] rdata_q, rdata_d;
    logic        timer_int_q, timer_int_d;

    logic [29:0] word;
    logic        wr, rd;
    logic [31:0] timer_inc;
    logic [31:0] rd_val;
    logic        unused_addr;

    assign word        = addr[31:2] & ADDR_MASK[31:2];
    assign wr          = en & (|wen);
    assign rd          = en & ~(|wen);
    assign unused_addr = ^addr[1:0];

    function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        rd_val = 32'h0;
        case (word)
            IdxLed:     rd_val = {16'h0, led_q};
            IdxSwitch:  rd_val = {24'h0, sw2_q};
            IdxTimer:   rd_val = timer_q;
            IdxCompare: rd_val = compare_q;
            IdxStatus:  rd_val = {30'h0, ien_q, pend_q};
            IdxScratch: rd_val = scratch_q;
            default:    rd_val = 32'h0;
        endcase
    end

    always_comb begin
        led_d       = led_q;
        compare_d   = compare_q;
        scratch_d   = scratch_q;
        ien_d       = ien_q;
        pend_d      = pend_q;
        sw1_d       = switch_in;
        sw2_d       = sw1_q;
        timer_inc   = timer_q + 32'd1;
        timer_d     = timer_inc;
        rdata_d     = rd ? rd_val : rdata_q;
        timer_int_d = pend_q & ien_q;

        if (wr) begin
            case (word)
                IdxLed: begin
                    if (wen[0]) led_d[7:0]  = wdata[7:0];
                    if (wen[1]) led_d[15:8] = wdata[15:8];
                end
                // Unwritten timer lanes keep counting
                IdxTimer:   timer_d   = lane_merge(timer_inc, wdata, wen);
                IdxCompare: compare_d = lane_merge(compare_q, wdata, wen);
                IdxStatus: begin
                    if (wen[0]) begin
                        ien_d = wdata[1];
                        if (wdata[0]) pend_d = 1'b0;
                    end
                end
                IdxScratch: scratch_d = lane_merge(scratch_q, wdata, wen);
                default: ;
            endcase
        end

        // A compare match overrides a simultaneous write-1-to-clear
        if (timer_q == compare_q) pend_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q       <= 16'hFFFF;
            sw1_q       <= 8'h0;
            sw2_q       <= 8'h0;
            timer_q     <= 32'h0;
            compare_q   <= 32'hFFFF_FFFF;
            pend_q      <= 1'b0;
            ien_q       <= 1'b0;
            scratch_q   <= 32'h0;
            rdata_q     <= 32'h0;
            timer_int_q <= 1'b0;
        end else begin
            led_q       <= led_d;
            sw1_q       <= sw1_d;
            sw2_q       <= sw2_d;
            timer_q     <= timer_d;
            compare_q   <= compare_d;
            pend_q      <= pend_d;
            ien_q       <= ien_d;
            scratch_q   <= scratch_d;
            rdata_q     <= rdata_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign rdata     = rdata_q;
    assign led_out   = led_q;
    assign timer_int = timer_int_q;

endmodule

// File: tb/tb_periph_sram_slave.sv
// Self-checking bench for periph_sram_slave: register-map vector table plus hand-written
// sequences for timer compare, wrap, switch synchronizer and asynchronous reset.
module tb_periph_sram_slave;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        en = 1'b0;
    logic [3:0]  wen = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic [7:0]  switch_in = 8'h0;
    logic [15:0] led_out;
    logic        timer_int;

    periph_sram_slave #(
        .ADDR_MASK(32'h0000_00FF)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .en       (en),
        .wen      (wen),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .switch_in(switch_in),
        .led_out  (led_out),
        .timer_int(timer_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        tbl[21];
    logic [31:0] sb[$];
    logic [31:0] last_rd = 32'h0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle; reads push their expectation and pop it once rdata has updated
    task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] e, input string name);
        logic [31:0] exp;
        en = 1'b1; wen = w; addr = a; wdata = d;
        if (w == 4'h0) sb.push_back(e);
        @(posedge clk);
        #1;
        en = 1'b0; wen = 4'h0;
        if (w == 4'h0) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL %s: got empty scoreboard expected one entry", name);
            end else begin
                exp = sb.pop_front();
                check(name, rdata, exp);
                last_rd = exp;
            end
        end else begin
            check({name, " rdata hold"}, rdata, last_rd);
        end
    endtask

    task automatic idle(input string name);
        en = 1'b0; wen = 4'h0;
        @(posedge clk);
        #1;
        check({name, " rdata hold"}, rdata, last_rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'h0, 32'h0000_0000, 32'h0,          32'h0000_FFFF};
        tbl[1]  = '{4'h0, 32'h0000_000C, 32'h0,          32'hFFFF_FFFF};
        tbl[2]  = '{4'h0, 32'h0000_0014, 32'h0,          32'h0000_0000};
        tbl[3]  = '{4'h0, 32'h0000_0010, 32'h0,          32'h0000_0000};
        tbl[4]  = '{4'h5, 32'h0000_0014, 32'h1234_5678,  32'h0};
        tbl[5]  = '{4'h0, 32'h0000_0014, 32'h0,          32'h0034_0078};
        tbl[6]  = '{4'hF, 32'h0000_0000, 32'hA5A5_1234,  32'h0};
        tbl[7]  = '{4'h0, 32'h0000_0000, 32'h0,          32'h0000_1234};
        tbl[8]  = '{4'h2, 32'h0000_0000, 32'h0000_AB00,  32'h0};
        tbl[9]  = '{4'h0, 32'h0000_0000, 32'h0,          32'h0000_AB34};
        tbl[10] = '{4'hF, 32'h0000_0040, 32'hFFFF_FFFF,  32'h0};
        tbl[11] = '{4'h0, 32'h0000_0040, 32'h0,          32'h0000_0000};
        tbl[12] = '{4'h0, 32'h0000_0100, 32'h0,          32'h0000_AB34};
        tbl[13] = '{4'h0, 32'h0000_0003, 32'h0,          32'h0000_AB34};
        tbl[14] = '{4'hF, 32'h0000_0004, 32'hFFFF_FFFF,  32'h0};
        tbl[15] = '{4'h0, 32'h0000_0004, 32'h0,          32'h0000_0000};
        tbl[16] = '{4'h8, 32'h0000_0014, 32'hDEAD_BEEF,  32'h0};
        tbl[17] = '{4'h0, 32'h0000_0014, 32'h0,          32'hDE34_0078};
        tbl[18] = '{4'h0, 32'h0000_0018, 32'h0,          32'h0000_0000};
        tbl[19] = '{4'h2, 32'h0000_0010, 32'h0000_0003,  32'h0};
        tbl[20] = '{4'h0, 32'h0000_0010, 32'h0,          32'h0000_0000};

        // Reset state
        #2 resetn = 1'b0;
        #20;
        check("reset led_out", {16'h0, led_out}, 32'h0000_FFFF);
        check("reset timer_int", {31'h0, timer_int}, 32'h0);
        check("reset rdata", rdata, 32'h0);
        @(posedge clk);
        #3 resetn = 1'b1;
        idle("post reset");

        // Register map vectors
        for (int i = 0; i < 21; i++) begin
            access(tbl[i].wen, tbl[i].addr, tbl[i].wdata, tbl[i].exp, $sformatf("vec%0d", i));
        end
        check("led_out after table", {16'h0, led_out}, 32'h0000_AB34);

        // Compare match sets PEND, interrupt follows one cycle later
        access(4'h1, 32'h10, 32'h2, 32'h0, "status ien");
        access(4'hF, 32'h08, 32'h0, 32'h0, "timer zero");
        access(4'hF, 32'h0C, 32'd20, 32'h0, "compare 20");
        for (int i = 0; i < 19; i++) idle("run to 20");
        check("int before match", {31'h0, timer_int}, 32'h0);
        idle("match edge");
        check("int at pend set", {31'h0, timer_int}, 32'h0);
        idle("int edge");
        check("int after pend", {31'h0, timer_int}, 32'h1);
        access(4'h0, 32'h10, 32'h0, 32'h3, "status pend ien");

        // Write-1-to-clear, then set-wins on a simultaneous match
        access(4'hF, 32'h0C, 32'd10, 32'h0, "compare 10");
        access(4'h1, 32'h10, 32'h3, 32'h0, "status clear");
        access(4'h0, 32'h10, 32'h0, 32'h2, "status cleared");
        check("int after clear", {31'h0, timer_int}, 32'h0);
        access(4'hF, 32'h08, 32'h0, 32'h0, "timer zero 2");
        for (int i = 0; i < 10; i++) idle("run to 10");
        check("int before match 2", {31'h0, timer_int}, 32'h0);
        access(4'h1, 32'h10, 32'h3, 32'h0, "clear at match");
        idle("set wins");
        check("int set wins", {31'h0, timer_int}, 32'h1);
        access(4'h0, 32'h10, 32'h0, 32'h3, "status set wins");

        // Timer wrap and partial-lane timer write
        access(4'hF, 32'h08, 32'hFFFF_FFFE, 32'h0, "timer near wrap");
        idle("wrap");
        idle("wrap");
        idle("wrap");
        access(4'h0, 32'h08, 32'h0, 32'h0000_0001, "timer wrapped");
        access(4'hE, 32'h08, 32'h1234_56FF, 32'h0, "timer upper lanes");
        access(4'h0, 32'h08, 32'h0, 32'h1234_5603, "timer merged");

        // Switch synchronizer latency
        switch_in = 8'hA5;
        idle("sync1");
        access(4'h0, 32'h04, 32'h0, 32'h0000_0000, "switch old");
        idle("sync wait");
        idle("sync wait");
        access(4'h0, 32'h04, 32'h0, 32'h0000_00A5, "switch new");
        access(4'hF, 32'h04, 32'h0, 32'h0, "switch write");
        access(4'h0, 32'h04, 32'h0, 32'h0000_00A5, "switch unchanged");

        // Asynchronous reset mid-count with a read pending
        access(4'h3, 32'h00, 32'h0, 32'h0, "led zero");
        check("led_out zero", {16'h0, led_out}, 32'h0);
        check("int before reset", {31'h0, timer_int}, 32'h1);
        en = 1'b1; wen = 4'h0; addr = 32'h0;
        #3 resetn = 1'b0;
        #1;
        check("async led_out", {16'h0, led_out}, 32'h0000_FFFF);
        check("async timer_int", {31'h0, timer_int}, 32'h0);
        check("async rdata", rdata, 32'h0);
        @(posedge clk);
        #1;
        check("read in reset", rdata, 32'h0);
        en = 1'b0;
        last_rd = 32'h0;
        #2 resetn = 1'b1;
        idle("first edge after reset");
        access(4'h0, 32'h08, 32'h0, 32'h0000_0001, "timer resumed");
        access(4'h0, 32'h40, 32'h0, 32'h0, "unmapped after reset");
        access(4'h0, 32'h00, 32'h0, 32'h0000_FFFF, "led after reset");

        check("scoreboard drained", sb.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
